// File: rtl/lifo_pkg.sv
// Shared types for the parametrised LIFO stack: operation encoding and
// the occupancy-count width helper.
package lifo_pkg;

   typedef enum logic [1:0] {
      LIFO_NOP,
      LIFO_PUSH,
      LIFO_POP,
      LIFO_REPLACE
   } lifo_op_e;

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/lifo_stack_param_if.sv
// Stack access bundle: push/pop requests, TOS/NOS views, occupancy and
// error flags. master drives requests, slave is the stack itself.
interface lifo_stack_if
   import lifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1024
);
   localparam int CW = cnt_w(DEPTH);

   logic             I_VALID;
   logic [WIDTH-1:0] I_DATA;
   logic             O_EN;
   logic             O_VALID;
   logic [WIDTH-1:0] O_DATA;
   logic [WIDTH-1:0] TOP_DATA;
   logic [WIDTH-1:0] NEXT_DATA;
   logic [CW-1:0]    COUNT;
   logic             FULL;
   logic             EMPTY;
   logic             CLR_ERR;
   logic             OVERFLOW;
   logic             UNDERFLOW;

   modport master (
      output I_VALID, I_DATA, O_EN, CLR_ERR,
      input  O_VALID, O_DATA, TOP_DATA, NEXT_DATA,
      input  COUNT, FULL, EMPTY, OVERFLOW, UNDERFLOW
   );

   modport slave (
      input  I_VALID, I_DATA, O_EN, CLR_ERR,
      output O_VALID, O_DATA, TOP_DATA, NEXT_DATA,
      output COUNT, FULL, EMPTY, OVERFLOW, UNDERFLOW
   );

endinterface

// File: rtl/lifo_spill_ram.sv
// Spill storage below NOS: DEPTH-2 entries, one synchronous write port
// and one asynchronous read port (maps to distributed RAM).
module lifo_spill_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH - 2)
) (
   input  logic             CLK,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH-2];

   always_ff @(posedge CLK) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lifo_stack_param.sv
// LIFO operand/return stack with TOS/NOS in registers and a spill RAM.
// Define LIFO_STACK_ERR_EN to build the sticky OVERFLOW/UNDERFLOW flags.
module lifo_stack_param
   import lifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1024
) (
   input  logic        CLK,
   input  logic        RST,
   lifo_stack_if.slave bus
);

   localparam int CW = cnt_w(DEPTH);
   localparam int AW = $clog2(DEPTH - 2);

   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_tos;
   logic [WIDTH-1:0] r_nos;

   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_repl;
   logic             w_rej_push;
   logic             w_rej_pop;
   lifo_op_e         w_op;
   logic             w_we;
   logic [AW-1:0]    w_waddr;
   logic [AW-1:0]    w_raddr;
   logic [WIDTH-1:0] w_spill_rd;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));

   // Push with pop on an empty stack degrades to a plain push.
   assign w_push = bus.I_VALID && (!bus.O_EN || w_empty) && !w_full;
   assign w_pop  = bus.O_EN && !bus.I_VALID && !w_empty;
   assign w_repl = bus.I_VALID && bus.O_EN && !w_empty;

   assign w_rej_push = bus.I_VALID && !bus.O_EN && w_full;
   assign w_rej_pop  = bus.O_EN && !bus.I_VALID && w_empty;

   always_comb begin
      w_op = LIFO_NOP;
      unique case (1'b1)
         w_push:  w_op = LIFO_PUSH;
         w_pop:   w_op = LIFO_POP;
         w_repl:  w_op = LIFO_REPLACE;
         default: w_op = LIFO_NOP;
      endcase
   end

   assign w_we    = (w_op == LIFO_PUSH) && (r_count >= CW'(2));
   assign w_waddr = AW'(r_count - CW'(2));
   assign w_raddr = AW'(r_count - CW'(3));

   lifo_spill_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_spill (
      .CLK     (CLK),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (r_nos),
      .i_raddr (w_raddr),
      .o_rdata (w_spill_rd)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_count <= '0;
         r_tos   <= '0;
         r_nos   <= '0;
      end else begin
         case (w_op)
            LIFO_PUSH: begin
               r_count <= r_count + CW'(1);
               r_tos   <= bus.I_DATA;
               r_nos   <= r_tos;
            end
            LIFO_POP: begin
               r_count <= r_count - CW'(1);
               r_tos   <= r_nos;
               // NOS refills from spill only when an entry lives there.
               r_nos   <= (r_count >= CW'(3)) ? w_spill_rd : '0;
            end
            LIFO_REPLACE: begin
               r_tos <= bus.I_DATA;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef LIFO_STACK_ERR_EN
   logic r_ovf;
   logic r_udf;

   // A rejection in the same cycle as CLR_ERR keeps the flag set.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (w_rej_push) begin
            r_ovf <= 1'b1;
         end else if (bus.CLR_ERR) begin
            r_ovf <= 1'b0;
         end
         if (w_rej_pop) begin
            r_udf <= 1'b1;
         end else if (bus.CLR_ERR) begin
            r_udf <= 1'b0;
         end
      end
   end

   assign bus.OVERFLOW  = r_ovf;
   assign bus.UNDERFLOW = r_udf;
`else
   logic w_unused_err;

   assign w_unused_err  = ^{bus.CLR_ERR, w_rej_push, w_rej_pop};
   assign bus.OVERFLOW  = 1'b0;
   assign bus.UNDERFLOW = 1'b0;
`endif

   assign bus.O_VALID   = bus.O_EN && !w_empty;
   assign bus.O_DATA    = r_tos;
   assign bus.TOP_DATA  = r_tos;
   assign bus.NEXT_DATA = r_nos;
   assign bus.COUNT     = r_count;
   assign bus.FULL      = w_full;
   assign bus.EMPTY     = w_empty;

endmodule
